freq_meas_seq: RTL and testbench
================================

Name: freq_meas_seq

Overview:
- Measurement sequencer for the frequency-meter datapath. It drives the 7-digit BCD pulse counter (clear, count-enable) and the 7-digit display holding register (capture strobe).
- Generates a precise gate window from the system clock, with selectable range.
- Supports single-shot and continuous measurement.
- Tracks counter overflow and reports it alongside each captured result.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; base for gate lengths (bench uses 1000).
- HOLD_CYC, 25_000_000, idle cycles between captured result and next clear in continuous mode (bench uses 20).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- run  input  1  level; 1 = continuous measurement
- single  input  1  one-cycle pulse; requests one measurement when idle
- range_sel  input  2  gate select: 0 = 1 s, 1 = 100 ms, 2 = 10 ms, 3 = treated as 1 s
- ovf_in  input  1  carry-out of the most significant counter digit
- cnt_clr  output  1  synchronous clear to the BCD counter
- cnt_en  output  1  count-enable (gate) to the BCD counter
- latch_stb  output  1  one-cycle capture strobe to the display register
- busy  output  1  high in every state except IDLE
- ovf_flag  output  1  overflow status of the last captured result
- range_act  output  2  range used by the current/last measurement
- meas_cnt  output  8  number of completed measurements, wraps 255 -> 0

Behaviour:
- Reset (rst = 0, any time, including mid-gate):
  - state IDLE; all outputs 0; internal timer 0; sticky overflow 0.
  - If reset is asserted during GATE, cnt_en drops immediately and no capture occurs.
- States and transitions:
  - IDLE: go to CLR when run = 1 or single = 1. A single pulse seen in any other state is ignored.
  - CLR: 1 cycle. cnt_clr = 1. Samples range_sel into range_act and loads the gate timer with G - 1. Clears sticky overflow. Next state GATE.
  - GATE: cnt_en = 1 for exactly G consecutive cycles (G = CLK_HZ, CLK_HZ/10 or CLK_HZ/100). ovf_in = 1 on any GATE cycle sets sticky overflow. Next state SETTLE when the timer reaches 0.
  - SETTLE: 1 cycle, cnt_en = 0, lets the final count propagate. Next state LATCH.
  - LATCH: 1 cycle. latch_stb = 1. ovf_flag <= sticky overflow. meas_cnt += 1. Next state HOLD if run = 1, else IDLE.
  - HOLD: HOLD_CYC cycles. Then CLR if run = 1, else IDLE.
- Latency: from the edge where run/single is sampled, cnt_clr is high on the next cycle, and latch_stb is exactly G + 3 cycles after that edge.
- range_sel changes outside CLR have no effect on a measurement in progress.
- run deasserted during CLR/GATE/SETTLE: the current measurement completes and is latched, then IDLE. run deasserted during HOLD: go to IDLE at the end of HOLD.
- run and single both high in IDLE: behaves as run.
- ovf_flag holds its value until the next LATCH or reset.
- Outputs are registered. cnt_clr, cnt_en, latch_stb and busy are glitch-free decodes of the state register.

Optional Feature:
- Macro AUTORANGE_EN.
- Defined: in LATCH, if sticky overflow = 1 and range_act != 2, no latch_stb is issued and meas_cnt is unchanged. range_act steps to the next shorter gate (0->1->2, 3->1) and the FSM returns to CLR immediately. In this mode CLR keeps the stepped range instead of sampling range_sel. range_sel is re-sampled on the next entry from IDLE or HOLD. Overflow at range 2 latches normally with ovf_flag = 1.
- Undefined: every measurement latches; overflow only sets ovf_flag.

Decomposition:
- Package freq_meas_pkg:
  - state encoding IDLE/CLR/GATE/SETTLE/LATCH/HOLD;
  - range codes;
  - gate-length function of range and CLK_HZ;
  - timer width constant clog2(CLK_HZ).
- Sub-module freq_gate_timer: a loadable down-counter with a load/enable/zero flag, shared by GATE and HOLD.

Test Plan:
- CLK_HZ=1000. single pulse, range 0: cnt_clr 1 cycle, then cnt_en high exactly 1000 cycles, latch_stb 1002 cycles after cnt_clr. meas_cnt = 1, busy returns 0.
- run = 1, range 2, HOLD_CYC=20: repeated cycles of period 1 + 10 + 1 + 1 + 20 = 33 cycles; meas_cnt = 3 after 3 latches. Drop run mid-gate: that measurement latches, then IDLE.
- ovf_in pulsed once mid-gate, range 1: ovf_flag = 1 after latch_stb. The next clean measurement yields ovf_flag = 0.
- rst low at gate cycle 50: cnt_en = 0 and all outputs 0 immediately, no latch_stb. After release, a single pulse restarts cleanly.
- range_sel changed 0 -> 2 mid-gate: gate still 1000 cycles, range_act = 0. The next measurement uses 10 cycles.
- AUTORANGE_EN, range 0, ovf_in during gate: no latch_stb, re-gate at 100 cycles. If clean, one latch_stb with range_act = 1 and meas_cnt = 1.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// -----------------------------------------------------------------------------
// freq_meas_pkg
// Shared definitions for the frequency-meter measurement sequencer:
//   - FSM state encoding (IDLE/CLR/GATE/SETTLE/LATCH/HOLD)
//   - gate range codes
//   - gate-length function of range and system clock frequency
//   - timer width helpers
// -----------------------------------------------------------------------------
package freq_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4,
        ST_HOLD   = 3'd5
    } meas_state_e;

    localparam logic [1:0] RNG_1S     = 2'd0;
    localparam logic [1:0] RNG_100MS  = 2'd1;
    localparam logic [1:0] RNG_10MS   = 2'd2;
    localparam logic [1:0] RNG_1S_ALT = 2'd3;

    localparam int unsigned CLK_HZ_DEF = 32'd50_000_000;
    localparam int unsigned TMR_W      = $clog2(CLK_HZ_DEF);

    // Gate length in system clock cycles; code 3 is treated as the 1 s gate.
    function automatic int unsigned gate_len(input logic [1:0] rng, input int unsigned clk_hz);
        case (rng)
            RNG_1S:     gate_len = clk_hz;
            RNG_100MS:  gate_len = clk_hz / 32'd10;
            RNG_10MS:   gate_len = clk_hz / 32'd100;
            RNG_1S_ALT: gate_len = clk_hz;
            default:    gate_len = clk_hz;
        endcase
    endfunction

    // Next shorter gate used when an overflowed measurement is retried.
    function automatic logic [1:0] next_shorter(input logic [1:0] rng);
        case (rng)
            RNG_100MS: next_shorter = RNG_10MS;
            RNG_10MS:  next_shorter = RNG_10MS;
            default:   next_shorter = RNG_100MS;
        endcase
    endfunction

    // The timer is shared by GATE and HOLD, so it must hold the larger load.
    function automatic int unsigned tmr_width(input int unsigned clk_hz, input int unsigned hold_cyc);
        int unsigned m;
        m = (clk_hz > hold_cyc) ? clk_hz : hold_cyc;
        tmr_width = $clog2(m) + 32'd1;
    endfunction

endpackage

// File: rtl/freq_gate_timer.sv
// -----------------------------------------------------------------------------
// freq_gate_timer
// Loadable down-counter shared by the GATE and HOLD states.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset (count -> 0)
//   i_load     - load i_load_val (has priority over i_en)
//   i_load_val - value to load
//   i_en       - decrement by one while the count is non-zero
//   o_zero     - count equals zero
// -----------------------------------------------------------------------------
module freq_gate_timer
    import freq_meas_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Down-counter register: load, decrement towards zero, or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != {W{1'b0}})) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/freq_meas_seq.sv
// -----------------------------------------------------------------------------
// freq_meas_seq
// Measurement sequencer for the frequency meter: clears the BCD pulse counter,
// opens a gate window of CLK_HZ, CLK_HZ/10 or CLK_HZ/100 cycles, lets the count
// settle, then strobes the display register. Single-shot or continuous.
//
// Optional feature (macro AUTORANGE_EN): an overflowed measurement on the
// 1 s / 100 ms ranges is discarded and retried on the next shorter gate.
//
// Ports:
//   clk, rst (async, active-low)
//   run        - level, continuous measurement
//   single     - one-cycle request, honoured only when idle
//   range_sel  - gate select (0 = 1 s, 1 = 100 ms, 2 = 10 ms, 3 = 1 s)
//   ovf_in     - carry-out of the most significant counter digit
//   cnt_clr    - counter clear
//   cnt_en     - counter enable (gate)
//   latch_stb  - one-cycle display capture strobe
//   busy       - sequencer not idle
//   ovf_flag   - overflow status of the last captured result
//   range_act  - range of the current / last measurement
//   meas_cnt   - completed measurements, wraps
//
// All outputs are flops decoded from the state register, so they trail the
// state by one cycle; the overflow monitor therefore watches the registered
// gate output, which is exactly the window the counter sees.
// -----------------------------------------------------------------------------
module freq_meas_seq
    import freq_meas_pkg::*;
#(
    parameter int unsigned CLK_HZ   = CLK_HZ_DEF,
    parameter int unsigned HOLD_CYC = 32'd25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       single,
    input  logic [1:0] range_sel,
    input  logic       ovf_in,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       latch_stb,
    output logic       busy,
    output logic       ovf_flag,
    output logic [1:0] range_act,
    output logic [7:0] meas_cnt
);

    localparam int unsigned TW = tmr_width(CLK_HZ, HOLD_CYC);

    meas_state_e r_state;
    meas_state_e w_next_state;

    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_load_val;
    logic          w_tmr_en;
    logic          w_tmr_zero;
    logic          w_autostep;
    logic [1:0]    w_clr_range;

    logic          r_cnt_clr;
    logic          r_cnt_en;
    logic          r_latch_stb;
    logic          r_busy;
    logic          r_ovf_flag;
    logic [1:0]    r_range_act;
    logic [7:0]    r_meas_cnt;
    logic          r_sticky_ovf;
    logic          r_keep_range;

    freq_gate_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

`ifdef AUTORANGE_EN
    assign w_autostep = (r_state == ST_LATCH) && r_sticky_ovf && (r_range_act != RNG_10MS);
`else
    assign w_autostep = 1'b0;
`endif

    // A retry keeps the stepped range; any fresh start samples range_sel.
    assign w_clr_range = r_keep_range ? r_range_act : range_sel;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and timer control.
    always_comb begin
        w_next_state   = r_state;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = {TW{1'b0}};
        w_tmr_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run || single) begin
                    w_next_state = ST_CLR;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CLR: begin
                w_tmr_load     = 1'b1;
                w_tmr_load_val = TW'(gate_len(w_clr_range, CLK_HZ) - 32'd1);
                w_next_state   = ST_GATE;
            end
            ST_GATE: begin
                if (w_tmr_zero) begin
                    w_next_state = ST_SETTLE;
                end else begin
                    w_tmr_en     = 1'b1;
                    w_next_state = ST_GATE;
                end
            end
            ST_SETTLE: begin
                w_next_state = ST_LATCH;
            end
            ST_LATCH: begin
                if (w_autostep) begin
                    w_next_state = ST_CLR;
                end else if (run) begin
                    w_tmr_load     = 1'b1;
                    w_tmr_load_val = TW'(HOLD_CYC - 32'd1);
                    w_next_state   = ST_HOLD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (w_tmr_zero) begin
                    w_next_state = run ? ST_CLR : ST_IDLE;
                end else begin
                    w_tmr_en     = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered output decodes and measurement bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_clr    <= 1'b0;
            r_cnt_en     <= 1'b0;
            r_latch_stb  <= 1'b0;
            r_busy       <= 1'b0;
            r_ovf_flag   <= 1'b0;
            r_range_act  <= 2'd0;
            r_meas_cnt   <= 8'd0;
            r_sticky_ovf <= 1'b0;
            r_keep_range <= 1'b0;
        end else begin
            r_cnt_clr   <= (r_state == ST_CLR);
            r_cnt_en    <= (r_state == ST_GATE);
            r_latch_stb <= (r_state == ST_LATCH) && !w_autostep;
            r_busy      <= (r_state != ST_IDLE);

            if (r_state == ST_CLR) begin
                r_sticky_ovf <= 1'b0;
            end else if (r_cnt_en && ovf_in) begin
                r_sticky_ovf <= 1'b1;
            end else begin
                r_sticky_ovf <= r_sticky_ovf;
            end

            if (r_state == ST_CLR) begin
                r_range_act  <= w_clr_range;
                r_keep_range <= 1'b0;
            end else if (w_autostep) begin
                r_range_act  <= next_shorter(r_range_act);
                r_keep_range <= 1'b1;
            end else begin
                r_range_act  <= r_range_act;
                r_keep_range <= r_keep_range;
            end

            if ((r_state == ST_LATCH) && !w_autostep) begin
                r_ovf_flag <= r_sticky_ovf;
                r_meas_cnt <= r_meas_cnt + 8'd1;
            end else begin
                r_ovf_flag <= r_ovf_flag;
                r_meas_cnt <= r_meas_cnt;
            end
        end
    end

    assign cnt_clr   = r_cnt_clr;
    assign cnt_en    = r_cnt_en;
    assign latch_stb = r_latch_stb;
    assign busy      = r_busy;
    assign ovf_flag  = r_ovf_flag;
    assign range_act = r_range_act;
    assign meas_cnt  = r_meas_cnt;

endmodule

// File: tb/tb_freq_meas_seq.sv
// -----------------------------------------------------------------------------
// tb_freq_meas_seq
// Self-checking bench for freq_meas_seq with CLK_HZ = 1000, HOLD_CYC = 20.
// Time t counts rising edges after the edge that samples run/single (t = 0).
// -----------------------------------------------------------------------------
module tb_freq_meas_seq;

    localparam int CLK  = 1000;
    localparam int HOLD = 20;
`ifdef AUTORANGE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       run;
    logic       single;
    logic [1:0] range_sel;
    logic       ovf_in;
    logic       cnt_clr;
    logic       cnt_en;
    logic       latch_stb;
    logic       busy;
    logic       ovf_flag;
    logic [1:0] range_act;
    logic [7:0] meas_cnt;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] m_cnt;

    typedef struct {
        logic [1:0] rng;
        int         ovf_at;
        int         e_gates;
        int         e_en;
        int         e_lat;
        int         e_ovf;
        int         e_ract;
    } vec_t;

    freq_meas_seq #(
        .CLK_HZ   (CLK),
        .HOLD_CYC (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .single    (single),
        .range_sel (range_sel),
        .ovf_in    (ovf_in),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .latch_stb (latch_stb),
        .busy      (busy),
        .ovf_flag  (ovf_flag),
        .range_act (range_act),
        .meas_cnt  (meas_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a measurement is a list of gates; each costs G+3 cycles
    // from its clear edge to its capture. With autorange, an overflowed gate
    // on a range other than 10 ms is retried on the next shorter range.
    task automatic model(input logic [1:0] rng, input int ovf_at,
                         output int gates, output int en, output int lat,
                         output int ovf, output int ract);
        int r;
        int g;
        bit hit;
        bit stop;
        r = int'(rng);
        gates = 0; en = 0; lat = 0; ovf = 0; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!stop) begin
                g   = (r == 1) ? CLK / 10 : ((r == 2) ? CLK / 100 : CLK);
                hit = (ovf_at >= en) && (ovf_at < en + g);
                gates++;
                en  += g;
                lat += g + 3;
                if (AUTO && hit && (r != 2)) begin
                    r = (r == 1) ? 2 : 1;
                end else begin
                    stop = 1'b1;
                    ovf  = int'(hit);
                end
            end
        end
        ract = r;
    endtask

    // One single-shot measurement. ovf_in is pulsed on gate cycle ovf_at;
    // on gate cycle chg_at range_sel is switched to 2 and single is re-pulsed.
    task automatic do_meas(input string tag, input logic [1:0] rng, input int ovf_at,
                           input int chg_at, input int e_gates, input int e_en,
                           input int e_lat, input int e_ovf, input int e_ract);
        int t, en_idx, clr_n, clr_first, stb_n, stb_t, ovf_seen, ract_seen, cnt_seen;
        bit done;
        t = 0; en_idx = 0; clr_n = 0; clr_first = -1; stb_n = 0; stb_t = -1;
        ovf_seen = -1; ract_seen = -1; cnt_seen = -1; done = 1'b0;
        range_sel = rng;
        single    = 1'b1;
        @(negedge clk);
        single = 1'b0;
        while (!done && (t < 3000)) begin
            @(negedge clk);
            t++;
            single = 1'b0;
            ovf_in = 1'b0;
            if (cnt_clr) begin
                clr_n++;
                if (clr_first < 0) clr_first = t;
            end
            if (latch_stb) begin
                stb_n++;
                stb_t     = t;
                ovf_seen  = int'(ovf_flag);
                ract_seen = int'(range_act);
                cnt_seen  = int'(meas_cnt);
            end
            if (cnt_en) begin
                if (en_idx == ovf_at) ovf_in = 1'b1;
                if (en_idx == chg_at) begin
                    range_sel = 2'd2;
                    single    = 1'b1;
                end
                en_idx++;
            end
            if ((stb_n > 0) && !busy) done = 1'b1;
        end
        m_cnt = m_cnt + 8'd1;
        chk({tag, ".finished"},  done,      1);
        chk({tag, ".clr_first"}, clr_first, 1);
        chk({tag, ".clr_n"},     clr_n,     e_gates);
        chk({tag, ".en_cycles"}, en_idx,    e_en);
        chk({tag, ".stb_n"},     stb_n,     1);
        chk({tag, ".stb_t"},     stb_t,     e_lat);
        chk({tag, ".ovf_flag"},  ovf_seen,  e_ovf);
        chk({tag, ".range_act"}, ract_seen, e_ract);
        chk({tag, ".meas_cnt"},  cnt_seen,  int'(m_cnt));
    endtask

    task automatic meas_model(input string tag, input logic [1:0] rng, input int ovf_at, input int chg_at);
        int gates, en, lat, ovf, ract;
        model(rng, ovf_at, gates, en, lat, ovf, ract);
        do_meas(tag, rng, ovf_at, chg_at, gates, en, lat, ovf, ract);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        int   t, nl, nclr, en_idx, g0, oa, stb_cnt, busy_cnt;
        int   lt [8];
        int   gates, en, lat, ovf, ract;
        logic [1:0] rr;
        bit   done;

        //             rng   ovf  gates  en    lat   ovf ract
        tbl[0] = '{2'd0, -1, 1, 1000, 1003, 0, 0};
        tbl[1] = '{2'd1, -1, 1,  100,  103, 0, 1};
        tbl[2] = '{2'd2, -1, 1,   10,   13, 0, 2};
        tbl[3] = '{2'd3, -1, 1, 1000, 1003, 0, 3};
        tbl[4] = '{2'd2,  0, 1,   10,   13, 1, 2};
        tbl[5] = '{2'd2, -1, 1,   10,   13, 0, 2};
        tbl[6] = '{2'd2,  9, 1,   10,   13, 1, 2};

        rst = 1'b0; run = 1'b0; single = 1'b0; ovf_in = 1'b0; range_sel = 2'd0;
        m_cnt = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset.outputs", {cnt_clr, cnt_en, latch_stb, busy, ovf_flag, range_act, meas_cnt}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_meas($sformatf("tbl%0d", i), tbl[i].rng, tbl[i].ovf_at, -1, tbl[i].e_gates,
                    tbl[i].e_en, tbl[i].e_lat, tbl[i].e_ovf, tbl[i].e_ract);
        end

        // Range change and single pulse mid-gate do not disturb the measurement.
        meas_model("rchg", 2'd0, -1, 10);
        meas_model("after_rchg", 2'd2, -1, -1);

        // Overflow on the 100 ms range, then a clean measurement.
        meas_model("ovf_r1", 2'd1, 50, -1);
        meas_model("clean_r1", 2'd1, -1, -1);
        // Overflow on the long ranges (retried when autorange is built in).
        meas_model("ovf_r0", 2'd0, 500, -1);
        meas_model("ovf_r3", 2'd3, 5, -1);

        // Continuous mode, 10 ms range; run dropped during the fourth gate.
        range_sel = 2'd2;
        run       = 1'b1;
        @(negedge clk);
        t = 0; nl = 0; nclr = 0; done = 1'b0;
        while (!done && (t < 400)) begin
            @(negedge clk);
            t++;
            if (cnt_clr) nclr++;
            if (latch_stb) begin
                if (nl < 8) lt[nl] = t;
                nl++;
                m_cnt = m_cnt + 8'd1;
                chk("run.meas_cnt", meas_cnt, m_cnt);
            end
            if ((nl == 3) && cnt_en) run = 1'b0;
            if (!run && (nl >= 4) && !busy) done = 1'b1;
        end
        run = 1'b0;
        chk("run.finished", done, 1);
        chk("run.latches", nl, 4);
        chk("run.clears", nclr, 4);
        chk("run.first_latch", lt[0], 13);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("run.period%0d", i), lt[i] - lt[i-1], 1 + 10 + 1 + 1 + HOLD);
        end

        // Randomized single shots against the model.
        for (int i = 0; i < 10; i++) begin
            rr = 2'($urandom_range(3, 0));
            model(rr, -1, gates, en, lat, ovf, ract);
            g0 = en;
            if ($urandom_range(1, 0) == 1) oa = int'($urandom_range(g0 - 1, 0));
            else oa = -1;
            meas_model($sformatf("rand%0d", i), rr, oa, -1);
        end

        // Reset during the gate: everything drops at once, no capture follows.
        range_sel = 2'd0;
        single    = 1'b1;
        @(negedge clk);
        single = 1'b0;
        en_idx = 0; t = 0;
        while ((en_idx < 50) && (t < 200)) begin
            @(negedge clk);
            t++;
            if (cnt_en) en_idx++;
        end
        chk("rst.reach_gate50", en_idx, 50);
        rst = 1'b0;
        #1;
        chk("rst.outputs_now", {cnt_clr, cnt_en, latch_stb, busy, ovf_flag, range_act, meas_cnt}, 0);
        m_cnt = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        stb_cnt = 0; busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (latch_stb) stb_cnt++;
            if (busy) busy_cnt++;
        end
        chk("rst.no_latch", stb_cnt, 0);
        chk("rst.stays_idle", busy_cnt, 0);
        meas_model("restart", 2'd2, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
